fpargmin_stream: RTL and testbench

- Streaming floating-point arg-min engine for ANN search. Consumes one query's candidate distances as a stream of beats, each carrying LN (index, distance) lanes. Returns the single nearest candidate (index + distance) per query.
- Successor of the two-input pairwise min cell: lane count is parametrised and the block accumulates across beats.
- Uses an order-key comparator instead of a subtractor, with valid/ready handshakes on both sides.

---
 rtl/fpargmin_pkg.sv | 52 +++++
 rtl/fpargmin_tree.sv | 73 +++++++
 rtl/fpargmin_stream.sv | 195 +++++++++++++++++++
 tb/tb_fpargmin_stream.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpargmin_pkg.sv
// fpargmin_pkg
// Shared definitions for the streaming floating-point arg-min engine:
//   state_t    : control states (ACC, DRAIN, HOLD)
//   fp_key     : maps an IEEE-754 pattern to an unsigned order key
//   fp_pinf    : +Inf bit pattern for a given data/exponent width
//   fp_is_nan  : exponent all ones with a nonzero mantissa
//   EMPTY_IDX  : all-ones index reported for an empty query (slice to IW)
// Widths up to 32 bits are supported; callers zero-extend into MAX_W.
package fpargmin_pkg;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int unsigned MAX_W = 32;
   localparam logic [MAX_W-1:0] EMPTY_IDX = {MAX_W{1'b1}};

   // Negative values are bit-inverted, positive values get the MSB set, so
   // an unsigned compare of keys orders -NaN < -Inf < ... < -0 < +0 < ... < +Inf < +NaN.
   function automatic logic [MAX_W-1:0] fp_key(input logic [MAX_W-1:0] x,
                                                input int unsigned dw);
      logic [MAX_W-1:0] msb;
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] key;
      msb  = 32'd1 << (dw - 32'd1);
      mask = (dw >= MAX_W) ? {MAX_W{1'b1}} : ((32'd1 << dw) - 32'd1);
      if ((x & msb) != 32'd0) begin
         key = ~x & mask;
      end else begin
         key = (x | msb) & mask;
      end
      return key;
   endfunction

   function automatic logic [MAX_W-1:0] fp_pinf(input int unsigned dw,
                                                 input int unsigned ew);
      return ((32'd1 << ew) - 32'd1) << (dw - 32'd1 - ew);
   endfunction

   function automatic logic fp_is_nan(input logic [MAX_W-1:0] x,
                                      input int unsigned dw,
                                      input int unsigned ew);
      logic [MAX_W-1:0] exp_mask;
      logic [MAX_W-1:0] man_mask;
      exp_mask = fp_pinf(dw, ew);
      man_mask = (32'd1 << (dw - 32'd1 - ew)) - 32'd1;
      return ((x & exp_mask) == exp_mask) && ((x & man_mask) != 32'd0);
   endfunction

endpackage

// File: rtl/fpargmin_tree.sv
// fpargmin_tree
// Combinational arg-min over LN lanes, log2(LN) levels deep.
//   msk : per-lane valid
//   idx : lane indices, lane 0 in LSBs
//   dat : lane values, lane 0 in LSBs
//   any : at least one lane valid
//   mi  : index of the minimum (0 when no lane valid)
//   md  : minimum value (0 when no lane valid)
// Ties resolve to the lower lane; also used as the two-way accumulator merge.
module fpargmin_tree
   import fpargmin_pkg::*;
#(
   parameter int DW = 32,
   parameter int IW = 8,
   parameter int LN = 4
) (
   input  logic [LN-1:0]    msk,
   input  logic [LN*IW-1:0] idx,
   input  logic [LN*DW-1:0] dat,
   output logic             any,
   output logic [IW-1:0]    mi,
   output logic [DW-1:0]    md
);

   // Heap layout: node n has children 2n+1 (lower lanes) and 2n+2; leaves
   // LN-1 .. 2LN-2 hold lanes 0 .. LN-1, so left-wins keeps the lane order.
   localparam int NN = 2 * LN - 1;

   logic [NN-1:0] node_vld_s;
   logic [IW-1:0] node_idx_s [NN];
   logic [DW-1:0] node_dat_s [NN];

   function automatic logic key_less(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [MAX_W-1:0] ea;
      logic [MAX_W-1:0] eb;
      ea = '0;
      eb = '0;
      ea[DW-1:0] = a;
      eb[DW-1:0] = b;
      return fp_key(ea, DW) < fp_key(eb, DW);
   endfunction

   // Reduce the leaves up to the root, right child wins only on a strictly smaller key.
   always_comb begin
      for (int n = 0; n < NN; n++) begin
         node_vld_s[n] = 1'b0;
         node_idx_s[n] = '0;
         node_dat_s[n] = '0;
      end
      for (int l = 0; l < LN; l++) begin
         node_vld_s[LN-1+l] = msk[l];
         node_idx_s[LN-1+l] = idx[l*IW +: IW];
         node_dat_s[LN-1+l] = dat[l*DW +: DW];
      end
      for (int n = LN - 2; n >= 0; n--) begin
         if (node_vld_s[2*n+2] &&
             (!node_vld_s[2*n+1] || key_less(node_dat_s[2*n+2], node_dat_s[2*n+1]))) begin
            node_vld_s[n] = 1'b1;
            node_idx_s[n] = node_idx_s[2*n+2];
            node_dat_s[n] = node_dat_s[2*n+2];
         end else begin
            node_vld_s[n] = node_vld_s[2*n+1];
            node_idx_s[n] = node_vld_s[2*n+1] ? node_idx_s[2*n+1] : '0;
            node_dat_s[n] = node_vld_s[2*n+1] ? node_dat_s[2*n+1] : '0;
         end
      end
   end

   assign any = node_vld_s[0];
   assign mi  = node_idx_s[0];
   assign md  = node_dat_s[0];

endmodule

// File: rtl/fpargmin_stream.sv
// fpargmin_stream
// Streaming arg-min: each query arrives as beats of LN (index, distance)
// lanes; one (index, distance) result is returned per query.
//   clk, rst             : clock, synchronous active-high reset
//   in_vld/in_rdy/in_lst : input beat handshake, last-beat marker
//   in_msk/in_idx/in_dat : per-lane valid, indices, distances (lane 0 in LSBs)
//   out_vld/out_rdy      : result handshake
//   out_mi/out_md        : index and value of the minimum
//   out_emp              : no unmasked lane in the whole query (mi all ones, md +Inf)
// Optional build macro FPARGMIN_NAN_SKIP_EN: NaN lanes are treated as masked.
module fpargmin_stream
   import fpargmin_pkg::*;
#(
   parameter int DW = 32,
   parameter int EW = 8,
   parameter int IW = 8,
   parameter int LN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic             in_lst,
   input  logic [LN-1:0]    in_msk,
   input  logic [LN*IW-1:0] in_idx,
   input  logic [LN*DW-1:0] in_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [IW-1:0]    out_mi,
   output logic [DW-1:0]    out_md,
   output logic             out_emp
);

   localparam logic [DW-1:0] PINF     = DW'(fp_pinf(DW, EW));
   localparam logic [IW-1:0] EMPTY_MI = EMPTY_IDX[IW-1:0];

   state_t          state_r, state_nxt_s;
   logic            in_rdy_r;
   logic [LN-1:0]   lane_msk_s;
   logic            red_any_s;
   logic [IW-1:0]   red_idx_s;
   logic [DW-1:0]   red_dat_s;
   logic            a_vld_r, a_lst_r, a_any_r;
   logic [IW-1:0]   a_idx_r;
   logic [DW-1:0]   a_dat_r;
   logic            acc_any_r;
   logic [IW-1:0]   acc_idx_r;
   logic [DW-1:0]   acc_dat_r;
   logic            m_any_s;
   logic [IW-1:0]   m_idx_s;
   logic [DW-1:0]   m_dat_s;
   logic            out_vld_r, out_emp_r;
   logic [IW-1:0]   out_mi_r;
   logic [DW-1:0]   out_md_r;
   logic            beat_fire_s, fin_s, out_fire_s;

   assign beat_fire_s = in_vld & in_rdy_r;
   assign fin_s       = a_vld_r & a_lst_r;
   assign out_fire_s  = out_vld_r & out_rdy;

`ifdef FPARGMIN_NAN_SKIP_EN
   function automatic logic lane_is_nan(input logic [DW-1:0] d);
      logic [MAX_W-1:0] e;
      e = '0;
      e[DW-1:0] = d;
      return fp_is_nan(e, DW, EW);
   endfunction
`endif

   // Lanes that take part in the stage-A reduction.
   always_comb begin
      lane_msk_s = in_msk;
`ifdef FPARGMIN_NAN_SKIP_EN
      for (int l = 0; l < LN; l++) begin
         if (lane_is_nan(in_dat[l*DW +: DW])) begin
            lane_msk_s[l] = 1'b0;
         end else begin
            lane_msk_s[l] = in_msk[l];
         end
      end
`endif
   end

   fpargmin_tree #(.DW(DW), .IW(IW), .LN(LN)) u_beat_tree (
      .msk (lane_msk_s),
      .idx (in_idx),
      .dat (in_dat),
      .any (red_any_s),
      .mi  (red_idx_s),
      .md  (red_dat_s)
   );

   // Stage A: register the per-beat reduction with its flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_vld_r <= 1'b0;
         a_lst_r <= 1'b0;
         a_any_r <= 1'b0;
         a_idx_r <= '0;
         a_dat_r <= '0;
      end else begin
         a_vld_r <= beat_fire_s;
         if (beat_fire_s) begin
            a_lst_r <= in_lst;
            a_any_r <= red_any_s;
            a_idx_r <= red_idx_s;
            a_dat_r <= red_dat_s;
         end
      end
   end

   // Accumulator sits in lane 0 so that it wins ties against the newer beat.
   fpargmin_tree #(.DW(DW), .IW(IW), .LN(2)) u_merge (
      .msk ({a_any_r, acc_any_r}),
      .idx ({a_idx_r, acc_idx_r}),
      .dat ({a_dat_r, acc_dat_r}),
      .any (m_any_s),
      .mi  (m_idx_s),
      .md  (m_dat_s)
   );

   // Stage B accumulator: merge each beat, return to empty when the query closes.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_any_r <= 1'b0;
         acc_idx_r <= '0;
         acc_dat_r <= '0;
      end else if (a_vld_r) begin
         if (a_lst_r) begin
            acc_any_r <= 1'b0;
            acc_idx_r <= '0;
            acc_dat_r <= '0;
         end else begin
            acc_any_r <= m_any_s;
            acc_idx_r <= m_idx_s;
            acc_dat_r <= m_dat_s;
         end
      end
   end

   // Output register: loaded from the merge on the last beat, held until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_r <= 1'b0;
         out_emp_r <= 1'b0;
         out_mi_r  <= '0;
         out_md_r  <= '0;
      end else if (fin_s) begin
         out_vld_r <= 1'b1;
         out_emp_r <= ~m_any_s;
         out_mi_r  <= m_any_s ? m_idx_s : EMPTY_MI;
         out_md_r  <= m_any_s ? m_dat_s : PINF;
      end else if (out_fire_s) begin
         out_vld_r <= 1'b0;
      end
   end

   // Next-state logic: one query in flight at a time.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ACC: begin
            if (beat_fire_s && in_lst) state_nxt_s = DRAIN;
            else                       state_nxt_s = ACC;
         end
         DRAIN: begin
            if (fin_s) state_nxt_s = HOLD;
            else       state_nxt_s = DRAIN;
         end
         HOLD: begin
            if (out_fire_s) state_nxt_s = ACC;
            else            state_nxt_s = HOLD;
         end
         default: state_nxt_s = ACC;
      endcase
   end

   // State register; in_rdy is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ACC;
         in_rdy_r <= 1'b1;
      end else begin
         state_r  <= state_nxt_s;
         in_rdy_r <= (state_nxt_s == ACC);
      end
   end

   assign in_rdy  = in_rdy_r;
   assign out_vld = out_vld_r;
   assign out_emp = out_emp_r;
   assign out_mi  = out_mi_r;
   assign out_md  = out_md_r;

endmodule

// File: tb/tb_fpargmin_stream.sv
// tb_fpargmin_stream
// Randomized and directed stimulus for fpargmin_stream (DW=32, IW=8, LN=4).
// Expected results come from a value-level model over a table of known
// floating-point constants and are queued; a monitor pops and compares on
// every result handshake and checks hold stability under backpressure.
module tb_fpargmin_stream;

   localparam int DW = 32;
   localparam int EW = 8;
   localparam int IW = 8;
   localparam int LN = 4;
   localparam int NP = 14;
   localparam int NAN_P = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_vld, in_rdy, in_lst;
   logic [LN-1:0]    in_msk;
   logic [LN*IW-1:0] in_idx;
   logic [LN*DW-1:0] in_dat;
   logic             out_vld, out_rdy, out_emp;
   logic [IW-1:0]    out_mi;
   logic [DW-1:0]    out_md;

   int   rdy_mode;   // 0: low, 1: high, 2: random
   logic rnd_rdy;
   assign out_rdy = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

   fpargmin_stream #(.DW(DW), .EW(EW), .IW(IW), .LN(LN)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_lst(in_lst),
      .in_msk(in_msk), .in_idx(in_idx), .in_dat(in_dat),
      .out_vld(out_vld), .out_rdy(out_rdy),
      .out_mi(out_mi), .out_md(out_md), .out_emp(out_emp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

   logic [31:0] pool_bits [NP];
   real         pool_val  [NP];

   int          bp [8][LN];
   logic [7:0]  bi [8][LN];
   logic [3:0]  bm [8];
   int          nb;

   typedef struct packed {
      logic        emp;
      logic [7:0]  mi;
      logic [31:0] md;
   } res_t;

   res_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Value ordering: +NaN above everything, -0 below +0, otherwise real compare.
   function automatic bit less(input int a, input int b);
      if (a == NAN_P) return 1'b0;
      if (b == NAN_P) return 1'b1;
      if (pool_val[a] < pool_val[b]) return 1'b1;
      if (a == 1 && b == 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic res_t model();
      res_t r;
      int   best = -1;
      logic [7:0] bidx = 8'd0;
      for (int b = 0; b < nb; b++) begin
         for (int l = 0; l < LN; l++) begin
            if (bm[b][l]) begin
`ifdef FPARGMIN_NAN_SKIP_EN
               if (bp[b][l] == NAN_P) continue;
`endif
               if (best < 0 || less(bp[b][l], best)) begin
                  best = bp[b][l];
                  bidx = bi[b][l];
               end
            end
         end
      end
      if (best < 0) begin
         r.emp = 1'b1; r.mi = 8'hFF; r.md = 32'h7F800000;
      end else begin
         r.emp = 1'b0; r.mi = bidx; r.md = pool_bits[best];
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_beat(input int b, input logic lst);
      int guard = 0;
      in_vld = 1'b1;
      in_lst = lst;
      in_msk = bm[b];
      for (int l = 0; l < LN; l++) begin
         in_idx[l*IW +: IW] = bi[b][l];
         in_dat[l*DW +: DW] = pool_bits[bp[b][l]];
      end
      while (!in_rdy && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!in_rdy) begin
         checks++; errors++;
         $display("FAIL in_rdy_timeout: actual 0 required 1 (t=%0t)", $time);
      end
      @(negedge clk);
      in_vld = 1'b0;
      in_lst = 1'b0;
   endtask

   task automatic send_query();
      for (int b = 0; b < nb; b++) send_beat(b, (b == nb - 1));
      exp_q.push_back(model());
   endtask

   task automatic set_rdy(input int m);
      @(posedge clk);
      #1 rdy_mode = m;
      @(negedge clk);
   endtask

   task automatic set_lane(input int b, input int l, input int p, input logic [7:0] idx, input logic v);
      bp[b][l] = p;
      bi[b][l] = idx;
      bm[b][l] = v;
   endtask

   task automatic clear_beats();
      for (int b = 0; b < 8; b++) begin
         bm[b] = 4'b0000;
         for (int l = 0; l < LN; l++) begin
            bp[b][l] = int'($urandom_range(0, NP - 1));
            bi[b][l] = 8'($urandom_range(0, 255));
         end
      end
   endtask

   task automatic wait_out_vld(input string name);
      int guard = 0;
      while (!out_vld && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk(name, 64'(out_vld), 64'd1);
   endtask

   // Monitor: compare each transferred result, check holding behaviour.
   logic prev_hold = 1'b0;
   res_t prev_out;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold <= 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_vld", 64'(out_vld), 64'd1);
            chk("hold_data", 64'({out_emp, out_mi, out_md}), 64'(prev_out));
         end
         if (out_vld) chk("in_rdy_while_out_vld", 64'(in_rdy), 64'd0);
         if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result: actual mi=%0h md=%0h required none", out_mi, out_md);
            end else begin
               chk("result", 64'({out_emp, out_mi, out_md}), 64'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
         prev_hold <= out_vld && !out_rdy;
         prev_out  <= {out_emp, out_mi, out_md};
      end
   end

   initial begin
      pool_bits[0]  = 32'h00000000; pool_val[0]  = 0.0;
      pool_bits[1]  = 32'h80000000; pool_val[1]  = 0.0;
      pool_bits[2]  = 32'h3F800000; pool_val[2]  = 1.0;
      pool_bits[3]  = 32'hBF800000; pool_val[3]  = -1.0;
      pool_bits[4]  = 32'h3E800000; pool_val[4]  = 0.25;
      pool_bits[5]  = 32'hC0000000; pool_val[5]  = -2.0;
      pool_bits[6]  = 32'h40E00000; pool_val[6]  = 7.0;
      pool_bits[7]  = 32'h7F800000; pool_val[7]  = 1.0e30;
      pool_bits[8]  = 32'hFF800000; pool_val[8]  = -1.0e30;
      pool_bits[9]  = 32'h7FC00000; pool_val[9]  = 0.0;
      pool_bits[10] = 32'h42C80000; pool_val[10] = 100.0;
      pool_bits[11] = 32'hBFC00000; pool_val[11] = -1.5;
      pool_bits[12] = 32'h40000000; pool_val[12] = 2.0;
      pool_bits[13] = 32'h3F000000; pool_val[13] = 0.5;

      rst = 1'b1; in_vld = 1'b0; in_lst = 1'b0; in_msk = '0; in_idx = '0; in_dat = '0;
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_in_rdy",  64'(in_rdy),  64'd1);
      chk("rst_out_md",  64'(out_md),  64'd0);
      chk("rst_out_mi",  64'(out_mi),  64'd0);
      chk("rst_out_emp", 64'(out_emp), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single beat with a -1.5 tie between lanes 1 and 2.
      clear_beats(); nb = 1;
      set_lane(0, 0, 12, 8'd0, 1'b1);
      set_lane(0, 1, 11, 8'd1, 1'b1);
      set_lane(0, 2, 11, 8'd2, 1'b1);
      set_lane(0, 3, 13, 8'd3, 1'b1);
      send_query();
      chk("lat_not_yet", 64'(out_vld), 64'd0);
      @(negedge clk);
      chk("lat_2", 64'(out_vld), 64'd1);
      chk("tie_mi", 64'(out_mi), 64'd1);
      chk("tie_md", 64'(out_md), 64'hBFC00000);

      // Three beats: 0.25 at idx 9 must survive a later 0.25 at idx 12.
      clear_beats(); nb = 3;
      set_lane(0, 0, 2, 8'd20, 1'b1);  set_lane(0, 1, 10, 8'd21, 1'b1);
      set_lane(0, 2, 12, 8'd22, 1'b1); set_lane(0, 3, 6, 8'd23, 1'b1);
      set_lane(1, 0, 10, 8'd8, 1'b1);  set_lane(1, 1, 4, 8'd9, 1'b1);
      set_lane(1, 2, 2, 8'd10, 1'b1);  set_lane(1, 3, 13, 8'd11, 1'b1);
      set_lane(2, 0, 4, 8'd12, 1'b1);  set_lane(2, 1, 12, 8'd13, 1'b1);
      set_lane(2, 2, 6, 8'd14, 1'b1);  set_lane(2, 3, 10, 8'd15, 1'b1);
      send_query();
      chk("drain_in_rdy", 64'(in_rdy), 64'd0);
      @(negedge clk);
      chk("three_mi", 64'(out_mi), 64'd9);
      chk("three_md", 64'(out_md), 64'h3E800000);

      // Backpressure: result held for 5 cycles, next query right after handshake.
      set_rdy(0);
      clear_beats(); nb = 1;
      set_lane(0, 3, 5, 8'd77, 1'b1);
      send_query();
      wait_out_vld("bp_out_vld");
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_rdy", 64'(in_rdy), 64'd0);
         chk("bp_mi", 64'(out_mi), 64'd77);
      end
      set_rdy(1);
      @(negedge clk);
      chk("post_hs_in_rdy", 64'(in_rdy), 64'd1);
      chk("post_hs_out_vld", 64'(out_vld), 64'd0);

      // Empty query over two beats.
      clear_beats(); nb = 2;
      send_query();
      @(negedge clk);
      chk("empty_emp", 64'(out_emp), 64'd1);
      chk("empty_mi", 64'(out_mi), 64'hFF);
      chk("empty_md", 64'(out_md), 64'h7F800000);

      // Signed zeros: -0 in lane 2 beats +0 in lane 0.
      clear_beats(); nb = 1;
      set_lane(0, 0, 0, 8'd40, 1'b1);
      set_lane(0, 2, 1, 8'd42, 1'b1);
      send_query();
      @(negedge clk);
      chk("zero_md", 64'(out_md), 64'h80000000);

      // Reset between beats 1 and 2 discards the query.
      clear_beats(); nb = 2;
      set_lane(0, 0, 8, 8'd50, 1'b1);
      send_beat(0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("rst_mid_no_out", 64'(out_vld), 64'd0);
      end
      clear_beats(); nb = 1;
      set_lane(0, 2, 6, 8'd4, 1'b1);
      send_query();
      @(negedge clk);
      chk("after_rst_mi", 64'(out_mi), 64'd4);
      chk("after_rst_md", 64'(out_md), 64'h40E00000);

      // NaN among positives never wins.
      clear_beats(); nb = 1;
      set_lane(0, 0, NAN_P, 8'd60, 1'b1);
      set_lane(0, 1, 2, 8'd61, 1'b1);
      set_lane(0, 2, 4, 8'd62, 1'b1);
      set_lane(0, 3, 10, 8'd63, 1'b1);
      send_query();
      @(negedge clk);
      chk("nan_mi", 64'(out_mi), 64'd62);

      // Randomized queries with random result backpressure.
      set_rdy(2);
      for (int q = 0; q < 40; q++) begin
         clear_beats();
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++)
            bm[b] = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         send_query();
      end

      set_rdy(1);
      for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
